// File: rtl/prod_accumulator.sv
// Sums COUNT_N multiplier products per frame with saturation; result held until handed off.
// Latency: out_valid one clk after the last accept; in_ready is low while a result waits.
module prod_accumulator #(
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       prod,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(COUNT_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_N);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_handoff;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sum_sat;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;

    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n & (r_state == ST_ACCUM) & ~clear;
    assign w_accept  = in_valid & in_ready;
    assign w_handoff = (r_state == ST_DONE) & out_ready & ~clear;

    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(prod);
    assign w_sum_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DONE;
                ST_DONE:  if (out_ready)          w_state_nxt = ST_ACCUM;
                default:                          w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clear || w_handoff) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum_sat;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_sum[ACC_W];
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench: default, 5-bit and single-beat instances driven from one stimulus stream.
module tb_prod_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] prod;
    logic       clear;
    logic       out_ready;

    logic       a_irdy, a_ovld, a_ovf;
    logic [7:0] a_acc;
    logic       s_irdy, s_ovld, s_ovf;
    logic [4:0] s_acc;
    logic       o_irdy, o_ovld, o_ovf;
    logic [7:0] o_acc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(8), .COUNT_N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_irdy), .prod(prod),
        .clear(clear), .out_valid(a_ovld), .out_ready(out_ready), .acc_out(a_acc), .ovf(a_ovf)
    );

    prod_accumulator #(.ACC_W(5), .COUNT_N(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_irdy), .prod(prod),
        .clear(clear), .out_valid(s_ovld), .out_ready(out_ready), .acc_out(s_acc), .ovf(s_ovf)
    );

    prod_accumulator #(.ACC_W(8), .COUNT_N(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_irdy), .prod(prod),
        .clear(clear), .out_valid(o_ovld), .out_ready(out_ready), .acc_out(o_acc), .ovf(o_ovf)
    );

    typedef struct {
        logic [3:0] prod;
        logic       vld;
        logic       clr;
        logic       ordy;
        logic       exp_irdy;
        logic [7:0] exp_acc;
        logic       exp_ovld;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] p, input logic v, input logic cl, input logic ordy);
        prod      = p;
        in_valid  = v;
        clear     = cl;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sb;

        rst_n = 1'b0;
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst acc_out", 32'(a_acc), 0);
        chk("rst out_valid", 32'(a_ovld), 0);
        chk("rst ovf", 32'(a_ovf), 0);
        chk("rst in_ready", 32'(a_irdy), 0);
        rst_n = 1'b1;

        // Basic frame, 5-cycle backpressure hold, handoff, then a second frame.
        vecs[0]  = '{4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9,  1'b0, 1'b0};
        vecs[1]  = '{4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'd15, 1'b0, 1'b0};
        vecs[2]  = '{4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd17, 1'b0, 1'b0};
        vecs[3]  = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
        for (int i = 4; i < 9; i++)
            vecs[i] = '{4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0};
        vecs[9]  = '{4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
        vecs[10] = '{4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
        vecs[11] = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0};
        vecs[12] = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
        vecs[13] = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0};
        vecs[14] = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].prod, vecs[i].vld, vecs[i].clr, vecs[i].ordy);
            #2;
            chk($sformatf("vec%0d in_ready", i), 32'(a_irdy), 32'(vecs[i].exp_irdy));
            tick();
            chk($sformatf("vec%0d acc_out", i), 32'(a_acc), 32'(vecs[i].exp_acc));
            chk($sformatf("vec%0d out_valid", i), 32'(a_ovld), 32'(vecs[i].exp_ovld));
            chk($sformatf("vec%0d ovf", i), 32'(a_ovf), 32'(vecs[i].exp_ovf));
        end

        // Saturation on the 5-bit instance.
        drive(4'd0, 1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin drive(4'd9, 1'b1, 1'b0, 1'b0); tick(); end
        chk("sat acc before", 32'(s_acc), 27);
        chk("sat ovf before", 32'(s_ovf), 0);
        tick();
        chk("sat acc", 32'(s_acc), 31);
        chk("sat ovf", 32'(s_ovf), 1);
        chk("sat out_valid", 32'(s_ovld), 1);
        drive(4'd0, 1'b0, 1'b0, 1'b1); tick();
        chk("sat ovf after handoff", 32'(s_ovf), 0);
        chk("sat acc after handoff", 32'(s_acc), 0);

        // Clear mid-frame with a competing product.
        drive(4'd0, 1'b0, 1'b1, 1'b0); tick();
        drive(4'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(4'd4, 1'b1, 1'b0, 1'b0); tick();
        chk("clr partial acc", 32'(a_acc), 7);
        drive(4'd5, 1'b1, 1'b1, 1'b0);
        #2;
        chk("clr in_ready", 32'(a_irdy), 0);
        tick();
        chk("clr acc", 32'(a_acc), 0);
        for (int i = 0; i < 3; i++) begin drive(4'd1, 1'b1, 1'b0, 1'b0); tick(); end
        chk("clr 3rd out_valid", 32'(a_ovld), 0);
        tick();
        chk("clr frame acc", 32'(a_acc), 4);
        chk("clr frame out_valid", 32'(a_ovld), 1);
        drive(4'd0, 1'b0, 1'b1, 1'b1); tick();
        chk("clr over out_ready", 32'(a_ovld), 0);

        // Asynchronous reset between edges after two accepts.
        drive(4'd2, 1'b1, 1'b0, 1'b0); tick(); tick();
        chk("ar partial acc", 32'(a_acc), 4);
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("ar acc", 32'(a_acc), 0);
        chk("ar in_ready", 32'(a_irdy), 0);
        chk("ar out_valid", 32'(a_ovld), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin drive(4'd2, 1'b1, 1'b0, 1'b0); tick(); end
        chk("ar frame acc", 32'(a_acc), 8);
        chk("ar frame out_valid", 32'(a_ovld), 1);
        drive(4'd0, 1'b0, 1'b0, 1'b1); tick();

        // Single-beat frames, including an out-of-range product value.
        drive(4'd0, 1'b0, 1'b1, 1'b0); tick();
        drive(4'd5, 1'b1, 1'b0, 1'b0); tick();
        chk("n1 acc", 32'(o_acc), 5);
        chk("n1 out_valid", 32'(o_ovld), 1);
        chk("n1 in_ready", 32'(o_irdy), 0);
        drive(4'd0, 1'b0, 1'b0, 1'b1); tick();
        chk("n1 handoff acc", 32'(o_acc), 0);
        drive(4'd15, 1'b1, 1'b0, 1'b0); tick();
        chk("n1 prod15 acc", 32'(o_acc), 15);
        chk("n1 prod15 out_valid", 32'(o_ovld), 1);

        // Every 2x2 multiplier pair, one frame per A operand.
        drive(4'd0, 1'b0, 1'b1, 1'b0); tick();
        for (int a = 0; a < 4; a++) begin
            sb = 0;
            for (int b = 0; b < 4; b++) begin
                drive(4'(a * b), 1'b1, 1'b0, 1'b0);
                tick();
                sb += a * b;
            end
            chk($sformatf("sweep a=%0d acc", a), 32'(a_acc), 32'(sb));
            chk($sformatf("sweep a=%0d out_valid", a), 32'(a_ovld), 1);
            drive(4'd0, 1'b0, 1'b0, 1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
